// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared widths and FSM state encoding for the data cache
package data_cache_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD_MISS = 2'd1;
  localparam logic [1:0] S_WR_THRU = 2'd2;
endpackage

// File: rtl/data_cache_array.sv
// cache_array: valid/tag/data storage, synchronous write, asynchronous read, reset clears valid only
module cache_array
  import data_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 26,
  localparam int IDX = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX-1:0]    widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX-1:0]    ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W-1:0] data [LINES];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end
  assign rvalid = valid[ridx];
  assign rtag = tags[ridx];
  assign rdata = data[ridx];
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through, write-no-allocate one-word-line data cache
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int MEM_LAT_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr_Mem,
  input  logic [DATA_W-1:0] writeData_Mem,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] readData_Mem,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout
);
  localparam int IDX = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - 2;
  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] look;
  logic [TAG_W-1:0] line_tag;
  logic [DATA_W-1:0] line_data;
  logic line_valid, hit, idle, rd_miss, we, unused_bits;
  assign idle = state == S_IDLE;
  assign rd_miss = state == S_RD_MISS;
  assign look = idle ? adr_Mem : mem_adr;
  assign unused_bits = ^look[1:0];
  assign hit = line_valid && line_tag == look[ADDR_W-1:IDX+2];
  assign we = !rst && !idle && mem_ready && (rd_miss || hit);
  cache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .widx   (look[IDX+1:2]),
    .wtag   (look[ADDR_W-1:IDX+2]),
    .wdata  (rd_miss ? mem_rdata : mem_wdata),
    .ridx   (look[IDX+1:2]),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );
  assign stall = !rst && (idle ? (memWrite || (memRead && !hit)) : !mem_ready);
  assign readData_Mem = (idle && memRead && !memWrite && hit) ? line_data :
                        (rd_miss && mem_ready) ? mem_rdata : rd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      timeout <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_adr <= '0;
      mem_wdata <= '0;
      rd_q <= '0;
    end else begin
      rd_q <= readData_Mem;
      if (idle) begin
        cnt <= '0;
        if (memWrite) begin
          state <= S_WR_THRU;
          mem_write <= 1'b1;
          mem_adr <= {adr_Mem[ADDR_W-1:2], 2'b00};
          mem_wdata <= writeData_Mem;
        end else if (memRead && !hit) begin
          state <= S_RD_MISS;
          mem_read <= 1'b1;
          mem_adr <= {adr_Mem[ADDR_W-1:2], 2'b00};
        end
      end else if (mem_ready) begin
        state <= S_IDLE;
        mem_read <= 1'b0;
        mem_write <= 1'b0;
      end else begin
        if (cnt != CNT_W'(MEM_LAT_MAX)) cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(MEM_LAT_MAX - 1)) timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: table-driven and directed self-checking bench for data_cache
module tb_data_cache;
  logic clk, rst, memRead, memWrite, mem_ready;
  logic [31:0] adr_Mem, writeData_Mem, mem_rdata;
  logic [31:0] readData_Mem, mem_adr, mem_wdata;
  logic stall, mem_read, mem_write, timeout;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic rd, wr;
    logic [31:0] adr, wd;
    int lat;
    logic [31:0] mrd;
    int stalls;
    logic chk_rd;
    logic [31:0] exp_rd;
    logic exp_mr, exp_mw;
  } vec_t;
  vec_t v[14];
  data_cache #(.LINES(16), .MEM_LAT_MAX(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .adr_Mem       (adr_Mem),
    .writeData_Mem (writeData_Mem),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .readData_Mem  (readData_Mem),
    .stall         (stall),
    .mem_adr       (mem_adr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .timeout       (timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic access(input vec_t t, output int stalls, output logic [31:0] rdo,
                        output logic mr, output logic mw, output logic both,
                        output logic [31:0] adr_s, output logic [31:0] wd_s);
    int waited;
    logic busy;
    stalls = 0;
    waited = 0;
    mr = 0;
    mw = 0;
    both = 0;
    adr_s = 0;
    wd_s = 0;
    rdo = 0;
    @(negedge clk);
    memRead = t.rd;
    memWrite = t.wr;
    adr_Mem = t.adr;
    writeData_Mem = t.wd;
    mem_ready = 0;
    mem_rdata = t.mrd;
    for (int c = 0; c < 200; c++) begin
      #1;
      busy = mem_read | mem_write;
      if (mem_read && mem_write) both = 1;
      if (mem_read) mr = 1;
      if (mem_write) mw = 1;
      if (busy) begin
        adr_s = mem_adr;
        wd_s = mem_wdata;
      end
      mem_ready = busy && waited == t.lat;
      #1;
      if (!stall) begin
        rdo = readData_Mem;
        break;
      end
      stalls++;
      if (busy) waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    memRead = 0;
    memWrite = 0;
    mem_ready = 0;
  endtask
  task automatic run_vec(input string name, input vec_t t);
    int st;
    logic [31:0] rdo, adr_s, wd_s;
    logic mr, mw, both;
    access(t, st, rdo, mr, mw, both, adr_s, wd_s);
    chk({name, " stall_cycles"}, st, t.stalls);
    chk({name, " mem_read_seen"}, {31'b0, mr}, {31'b0, t.exp_mr});
    chk({name, " mem_write_seen"}, {31'b0, mw}, {31'b0, t.exp_mw});
    chk({name, " rd_wr_overlap"}, {31'b0, both}, 32'b0);
    if (t.chk_rd) chk({name, " readData"}, rdo, t.exp_rd);
    if (t.exp_mr || t.exp_mw) chk({name, " mem_adr"}, adr_s, {t.adr[31:2], 2'b00});
    if (t.wr) chk({name, " mem_wdata"}, wd_s, t.wd);
  endtask
  initial begin
    v[0]  = '{1, 0, 32'h40, 0, 3, 32'h12345678, 4, 1, 32'h12345678, 1, 0};
    v[1]  = '{1, 0, 32'h40, 0, 0, 32'h0, 0, 1, 32'h12345678, 0, 0};
    v[2]  = '{0, 1, 32'h40, 32'hDEADBEEF, 0, 32'h0, 1, 0, 32'h0, 0, 1};
    v[3]  = '{1, 0, 32'h40, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0};
    v[4]  = '{0, 1, 32'h80, 32'hCAFEF00D, 2, 32'h0, 3, 0, 32'h0, 0, 1};
    v[5]  = '{1, 0, 32'h40, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0};
    v[6]  = '{1, 0, 32'h80, 0, 1, 32'h11112222, 2, 1, 32'h11112222, 1, 0};
    v[7]  = '{1, 0, 32'h00, 0, 0, 32'hAAAA0000, 1, 1, 32'hAAAA0000, 1, 0};
    v[8]  = '{1, 0, 32'h40, 0, 0, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 0};
    v[9]  = '{1, 0, 32'h00, 0, 0, 32'hAAAA0000, 1, 1, 32'hAAAA0000, 1, 0};
    v[10] = '{1, 1, 32'h00, 32'h00000055, 0, 32'h0, 1, 0, 32'h0, 0, 1};
    v[11] = '{1, 0, 32'h00, 0, 0, 32'h0, 0, 1, 32'h00000055, 0, 0};
    v[12] = '{1, 0, 32'hFFFFFFFC, 0, 0, 32'h00000077, 1, 1, 32'h00000077, 1, 0};
    v[13] = '{1, 0, 32'hFFFFFFFE, 0, 0, 32'h0, 0, 1, 32'h00000077, 0, 0};
    rst = 1;
    memRead = 1;
    memWrite = 0;
    adr_Mem = 0;
    writeData_Mem = 0;
    mem_ready = 0;
    mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1 chk("stall_in_rst", {31'b0, stall}, 32'b0);
    memRead = 0;
    rst = 0;
    @(negedge clk);
    #1;
    chk("rst timeout", {31'b0, timeout}, 32'b0);
    chk("rst mem_read", {31'b0, mem_read}, 32'b0);
    chk("rst mem_write", {31'b0, mem_write}, 32'b0);
    chk("rst readData", readData_Mem, 32'b0);
    chk("rst mem_adr", mem_adr, 32'b0);
    chk("rst mem_wdata", mem_wdata, 32'b0);
    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), v[i]);
    @(negedge clk);
    mem_ready = 1;
    mem_rdata = 32'h0BADBAD0;
    #1;
    chk("idle stall", {31'b0, stall}, 32'b0);
    chk("idle hold readData", readData_Mem, 32'h77);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("idle ready ignored mem_read", {31'b0, mem_read}, 32'b0);
    chk("idle ready ignored mem_write", {31'b0, mem_write}, 32'b0);
    chk("idle hold readData2", readData_Mem, 32'h77);
    @(negedge clk);
    memRead = 1;
    adr_Mem = 32'h100;
    #1 chk("midmiss stall", {31'b0, stall}, 32'b1);
    @(negedge clk);
    #1 chk("midmiss mem_read", {31'b0, mem_read}, 32'b1);
    @(negedge clk);
    rst = 1;
    memRead = 0;
    #1 chk("midmiss stall_in_rst", {31'b0, stall}, 32'b0);
    @(negedge clk);
    rst = 0;
    mem_ready = 1;
    mem_rdata = 32'h99999999;
    #1 chk("late ready stall", {31'b0, stall}, 32'b0);
    @(negedge clk);
    mem_ready = 0;
    #1 chk("late ready mem_read", {31'b0, mem_read}, 32'b0);
    run_vec("after_rst", '{1, 0, 32'h100, 0, 0, 32'h000100AA, 1, 1, 32'h000100AA, 1, 0});
    @(negedge clk);
    memRead = 1;
    adr_Mem = 32'h200;
    @(negedge clk);
    repeat (63) @(negedge clk);
    #1 chk("timeout at 63", {31'b0, timeout}, 32'b0);
    @(negedge clk);
    #1;
    chk("timeout at 64", {31'b0, timeout}, 32'b1);
    chk("timeout holds mem_read", {31'b0, mem_read}, 32'b1);
    chk("timeout holds stall", {31'b0, stall}, 32'b1);
    mem_ready = 1;
    mem_rdata = 32'h5;
    #1 chk("timeout release stall", {31'b0, stall}, 32'b0);
    @(negedge clk);
    mem_ready = 0;
    memRead = 0;
    #1;
    chk("timeout sticky", {31'b0, timeout}, 32'b1);
    chk("timeout done mem_read", {31'b0, mem_read}, 32'b0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("timeout cleared by rst", {31'b0, timeout}, 32'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 The block SHALL have parameter MEM_LAT_MAX, default 64, meaning the backing-memory wait cycles before a timeout flag is raised.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port adr_Mem, input, 32 bits, the byte address from the pipeline; bits [1:0] are ignored.
REQ-006 The block SHALL have port writeData_Mem, input, 32 bits, the pipeline store data.
REQ-007 The block SHALL have port memRead, input, 1 bit, the pipeline load request, level-held until not stalled.
REQ-008 The block SHALL have port memWrite, input, 1 bit, the pipeline store request, level-held until not stalled.
REQ-009 The block SHALL have port readData_Mem, output, 32 bits, the load data returned to the pipeline.
REQ-010 The block SHALL have port stall, output, 1 bit, which freezes the pipeline while high.
REQ-011 The block SHALL have port mem_adr, output, 32 bits, the backing-memory word-aligned address.
REQ-012 The block SHALL have port mem_wdata, output, 32 bits, the backing-memory write data.
REQ-013 The block SHALL have ports mem_read and mem_write, output, 1 bit each, the backing-memory requests, held until mem_ready.
REQ-014 The block SHALL have port mem_rdata, input, 32 bits, the backing-memory read data, valid when mem_ready is high.
REQ-015 The block SHALL have port mem_ready, input, 1 bit, the backing-memory completion strobe (one cycle).
REQ-016 The block SHALL have port timeout, output, 1 bit, a sticky error flag.

Function
REQ-017 Address split: index = adr_Mem[IDX+1:2], where IDX = log2(LINES); tag = adr_Mem[31:IDX+2].
REQ-018 Storage: per line, a valid bit, a tag and a 32-bit data word.
REQ-019 FSM states: IDLE, RD_MISS, WR_THRU.
REQ-020 IDLE, memRead, hit: readData_Mem = line data combinationally in the same cycle; stall=0; no backing-memory access.
REQ-021 IDLE, memRead, miss: stall=1 combinationally in the same cycle; the block SHALL go to RD_MISS and drive mem_read=1 and mem_adr={adr[31:2],2'b00} from the next cycle.
REQ-022 RD_MISS, mem_ready=1: the block SHALL write the line (valid=1, tag, mem_rdata), drive readData_Mem=mem_rdata, drive stall=0 in that cycle, and go to IDLE.
REQ-023 IDLE, memWrite: stall=1; the block SHALL go to WR_THRU with mem_write=1 and mem_wdata=writeData_Mem (write-through).
REQ-024 Write-no-allocate: a miss SHALL leave the cache unchanged.
REQ-025 WR_THRU, mem_ready=1: on a hit the line data SHALL be updated to the stored word; stall SHALL be 0 in that cycle; the FSM SHALL go to IDLE.
REQ-026 memRead and memWrite both high SHALL be treated as a write.
REQ-027 Neither request high: stall=0, and readData_Mem SHALL hold its last value.
REQ-028 mem_read and mem_write SHALL never both be high; they SHALL be low in IDLE.
REQ-029 A wait counter SHALL run in RD_MISS and WR_THRU; on reaching MEM_LAT_MAX, timeout SHALL be set (sticky until rst) and the request SHALL continue to be held.
REQ-030 mem_ready seen in IDLE SHALL be ignored.

Reset
REQ-031 On rst, all valid bits SHALL be cleared, the FSM SHALL go to IDLE, and the wait counter SHALL be set to 0.
REQ-032 Output reset values: timeout=0, mem_read=0, mem_write=0, readData_Mem=0, mem_adr=0, mem_wdata=0.
REQ-033 stall SHALL be 0 during rst.
REQ-034 Reset mid-miss or mid-write SHALL abandon the access, and a late mem_ready SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the DATA_W=32 and ADDR_W=32 constants.
REQ-036 A sub-module, cache_array, SHALL contain the valid/tag/data storage with a synchronous write port and an asynchronous read port, reset-clearing the valid bits only.
REQ-037 data_cache SHALL hold the FSM, hit compare, counters and muxing.

Verification
REQ-038 Cold read of 0x00000040, memory returns 0x12345678 after 3 cycles -> stall high 4 cycles, readData_Mem=0x12345678 on the release cycle; a repeat read hits with stall=0.
REQ-039 Write of 0xDEADBEEF to 0x40 (hit) -> mem_write with mem_adr=0x40; a subsequent read of 0x40 returns 0xDEADBEEF without mem_read.
REQ-040 Write of 0xCAFEF00D to 0x80 (miss) -> a read of 0x80 misses and issues mem_read with mem_adr=0x80.
REQ-041 Conflict: read 0x00 then read 0x40 (same index for LINES=16) -> the second read misses; a third read of 0x00 misses again.
REQ-042 Reset asserted during RD_MISS, followed by a late mem_ready -> the line stays invalid and stall=0 after reset.
REQ-043 mem_ready withheld for 64 cycles -> timeout=1 and stays set until rst.
